ddr_frame_streamer: RTL
=======================

// Module: ddr_frame_streamer
// PURPOSE
// - Read-side counterpart of the DDR camera frame writer: AXI4 read master fetching one stored frame
//   from its ping-pong DDR buffer and streaming it to the packet pipeline as 520-bit segments.
// - Each packet = 1 header segment + SEGS_PER_PKT payload segments; one payload segment = one 16-beat x 32-bit burst.
// - Sits between the frame controller (start/done handshakes) and the DDR AXI interconnect.
// PARAMETERS
// - BASE_ADDR0    32'h2BC0_0000  byte base of even buffer (odd_even_flag=0)
// - BASE_ADDR1    32'h2BE0_0000  byte base of odd buffer (odd_even_flag=1)
// - FRAME_BURSTS  9600           bursts per frame (153600 32-bit words)
// - SEGS_PER_PKT  16             payload segments per packet
// - DST_MAC 48'hADADADADADAD, SRC_MAC 48'hACACACACACAC, ETH_TYPE 16'h9000  header fields
// - TIMEOUT_CYC   4096           R-channel watchdog limit (FRAME_RD_TIMEOUT_EN only)
// PORTS
// - clk                    in   1    clock
// - aresetn                in   1    reset, asynchronous, active-low
// - frame_read_start_valid in   1    start request from controller
// - frame_read_start_ready out  1    high only in IDLE
// - odd_even_flag          in   1    buffer select, sampled on start handshake
// - frame_read_done        out  1    1=frame sent OK, 0=error/abort
// - frame_read_done_valid  out  1    held until frame_read_done_ready
// - frame_read_done_ready  in   1    controller accepts done
// - pktout_data            out  520  segment; [519:512]=0
// - pktout_en              out  1    one-cycle segment strobe
// - pktout_md              out  256  {16'd(pkt bytes), 16'd frame_seq, 16'd pkt_idx, 208'b0}
// - pktout_md_en           out  1    with pktout_en on last segment of a packet
// - pktout_alf             in   1    downstream almost-full; no segment issued while high
// - M_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  out 1/32/8/3/2  0 / addr / 8'd15 / 3'b010 / 2'b01
// - M_AXI_ARVALID out 1, M_AXI_ARREADY in 1    read address handshake
// - M_AXI_RDATA in 32, M_AXI_RRESP in 2, M_AXI_RLAST in 1, M_AXI_RVALID in 1, M_AXI_RREADY out 1
// BEHAVIOUR
// - Reset: FSM=IDLE; all outputs 0 except frame_read_start_ready=1; counters, frame_seq, error flag = 0.
// - States: IDLE -> HDR -> AR -> RD -> EMIT -> (AR | HDR | DONE) -> IDLE.
// - IDLE: on start_valid&&start_ready latch base=(odd_even_flag?BASE_ADDR1:BASE_ADDR0); burst_idx=0, pkt_idx=0, err=0.
// - HDR: when !pktout_alf, pktout_en=1 for 1 cycle, data[511:0]={DST_MAC,SRC_MAC,ETH_TYPE,frame_seq,pkt_idx,384'b0};
//   header never carries md_en. Earliest header strobe: 1 cycle after start handshake.
// - AR: ARVALID=1, ARADDR=base+{burst_idx,6'b0}; hold address stable until ARREADY; then RD.
// - RD: RREADY=1; each RVALID&&RREADY beat stores RDATA at gather[32*beat+:32], beat 0..15 (beat 0 = LSBs).
//   RRESP!=0 on any beat -> err=1 (sticky). RLAST must coincide with beat 15; mismatch -> err=1,
//   burst still ends at RLAST. After last beat RREADY drops next cycle -> EMIT.
// - EMIT: when !pktout_alf: pktout_en=1, pktout_data={8'b0,gather}; burst_idx++.
//   md_en=1 if segment is SEGS_PER_PKT-th of packet or burst_idx==FRAME_BURSTS-1 (short final packet allowed);
//   md pkt bytes = 64*(payload segs+1). Next: frame end -> DONE; packet end -> pkt_idx++, HDR; else AR.
// - DONE: done_valid=1, done=~err; on done_ready: frame_seq++ (16-bit wrap), IDLE.
// - Single outstanding burst; no AR/R overlap. alf high stalls only HDR/EMIT, never a burst in progress.
// - start_valid outside IDLE ignored (ready=0). Async reset mid-frame abandons burst; bus assumed reset together.
// CONFIGURATION
// - FRAME_RD_TIMEOUT_EN defined: counter clears on every R beat/AR accept; reaching TIMEOUT_CYC in AR or RD
//   sets err, drops ARVALID/RREADY, jumps to DONE (done=0); no further packets for that frame.
// - Undefined: no watchdog; block waits on AR/R indefinitely.
// TESTING
// - Start, odd_even_flag=0, ideal slave, FRAME_BURSTS=32 -> ARADDR 0x2BC00000..0x2BC007C0 step 64, 2 packets x
//   (1 hdr+16 payload), md_en on segs 17/34, md bytes=1088, done=1.
// - odd_even_flag=1, RDATA=beat index -> first payload data[31:0]=0, [511:480]=15, ARADDR=0x2BE00000.
// - pktout_alf high 50 cycles during EMIT -> no pktout_en until alf low, data unchanged, no extra AR.
// - RRESP=2'b10 on beat 7 of burst 3 -> frame completes, done_valid with done=0; next frame_seq incremented.
// - FRAME_BURSTS=20 -> second packet has 4 payload segs, md_en on seg 4, md bytes=320.
// - FRAME_RD_TIMEOUT_EN, slave stops RVALID mid-burst -> after 4096 cycles RREADY=0, done=0; reset mid-frame -> all outputs idle.

Source files
------------

// File: rtl/ddr_frame_streamer.sv
// ---------------------------------------------------------------------------
// ddr_frame_streamer
//
// Read side of the DDR camera frame path. On a start handshake it fetches one
// stored frame from the selected ping-pong DDR buffer. The fetch is a
// sequence of 16-beat x 32-bit AXI4 INCR bursts, with one burst outstanding
// at a time. Each burst is emitted as one 520-bit payload segment. Every
// packet opens with an Ethernet-style header segment. A packet then carries
// up to SEGS_PER_PKT payload segments; the last packet of a frame may be
// shorter.
//
// Optional feature (compile-time macro FRAME_RD_TIMEOUT_EN):
//   Enables an R-channel watchdog. It counts TIMEOUT_CYC cycles with no
//   AR accept or R beat while in AR or RD. When it expires, the frame is
//   abandoned and reported with frame_read_done = 0.
//   With the macro undefined, the block waits on AR/R indefinitely.
//
// Ports:
//   clk, aresetn                 clock, asynchronous active-low reset
//   frame_read_start_valid/ready start handshake (ready only while idle)
//   odd_even_flag                buffer select, sampled on start handshake
//   frame_read_done[_valid/ready] completion handshake, done=1 means no error
//   pktout_data/en               520-bit segment and one-cycle strobe
//   pktout_md/md_en              packet metadata on the last segment
//   pktout_alf                   downstream almost-full, stalls HDR/EMIT
//   M_AXI_AR*                    AXI4 read address channel (master)
//   M_AXI_R*                     AXI4 read data channel (master)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module ddr_frame_streamer #(
  parameter logic [31:0] BASE_ADDR0   = 32'h2BC0_0000,
  parameter logic [31:0] BASE_ADDR1   = 32'h2BE0_0000,
  parameter int          FRAME_BURSTS = 9600,
  parameter int          SEGS_PER_PKT = 16,
  parameter logic [47:0] DST_MAC      = 48'hADAD_ADAD_ADAD,
  parameter logic [47:0] SRC_MAC      = 48'hACAC_ACAC_ACAC,
  parameter logic [15:0] ETH_TYPE     = 16'h9000
`ifdef FRAME_RD_TIMEOUT_EN
  ,
  parameter int          TIMEOUT_CYC  = 4096
`endif
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         frame_read_start_valid,
  output logic         frame_read_start_ready,
  input  logic         odd_even_flag,
  output logic         frame_read_done,
  output logic         frame_read_done_valid,
  input  logic         frame_read_done_ready,
  output logic [519:0] pktout_data,
  output logic         pktout_en,
  output logic [255:0] pktout_md,
  output logic         pktout_md_en,
  input  logic         pktout_alf,
  output logic         M_AXI_ARID,
  output logic [31:0]  M_AXI_ARADDR,
  output logic [7:0]   M_AXI_ARLEN,
  output logic [2:0]   M_AXI_ARSIZE,
  output logic [1:0]   M_AXI_ARBURST,
  output logic         M_AXI_ARVALID,
  input  logic         M_AXI_ARREADY,
  input  logic [31:0]  M_AXI_RDATA,
  input  logic [1:0]   M_AXI_RRESP,
  input  logic         M_AXI_RLAST,
  input  logic         M_AXI_RVALID,
  output logic         M_AXI_RREADY
);

  localparam int BW      = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
  localparam int SW      = (SEGS_PER_PKT > 1) ? $clog2(SEGS_PER_PKT) : 1;
  // Header fields occupy the top 144 bits of the 512-bit segment body.
  localparam int HDR_PAD = 512 - 144;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_AR,
    S_RD,
    S_EMIT,
    S_DONE
  } state_t;

  state_t          state, state_next;
  logic [31:0]     base;
  logic [BW-1:0]   burst_idx;
  logic [SW-1:0]   seg_cnt;     // payload segments already sent in this packet
  logic [15:0]     pkt_idx;
  logic [15:0]     frame_seq;
  logic            err;
  logic [3:0]      beat;
  logic [511:0]    gather;

  logic            last_burst;
  logic            pkt_end;
  logic            ar_hs;
  logic            r_hs;
  logic            timeout;
  logic [15:0]     pkt_bytes;

  assign last_burst = (burst_idx == BW'(FRAME_BURSTS - 1));
  assign pkt_end    = (seg_cnt == SW'(SEGS_PER_PKT - 1)) || last_burst;
  assign ar_hs      = (state == S_AR) && M_AXI_ARREADY;
  assign r_hs       = (state == S_RD) && M_AXI_RVALID;
  // Header segment plus every payload segment, 64 bytes each.
  assign pkt_bytes  = 16'((int'(seg_cnt) + 2) * 64);

`ifdef FRAME_RD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wdog;

  // Counts stalled cycles only; any bus progress restarts the window.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wdog <= '0;
    end else if (!((state == S_AR) || (state == S_RD)) || ar_hs || r_hs) begin
      wdog <= '0;
    end else begin
      wdog <= wdog + 1'b1;
    end
  end

  assign timeout = ((state == S_AR) || (state == S_RD)) && !ar_hs && !r_hs &&
                   (wdog == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  // NOTE: every output gets a default before the case statement so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next             = state;
    frame_read_start_ready = 1'b0;
    frame_read_done        = 1'b0;
    frame_read_done_valid  = 1'b0;
    pktout_data            = '0;
    pktout_en              = 1'b0;
    pktout_md              = '0;
    pktout_md_en           = 1'b0;
    M_AXI_ARID             = 1'b0;
    M_AXI_ARADDR           = '0;
    M_AXI_ARLEN            = '0;
    M_AXI_ARSIZE           = '0;
    M_AXI_ARBURST          = '0;
    M_AXI_ARVALID          = 1'b0;
    M_AXI_RREADY           = 1'b0;

    case (state)
      S_IDLE: begin
        frame_read_start_ready = 1'b1;
        if (frame_read_start_valid) state_next = S_HDR;
      end

      S_HDR: begin
        if (!pktout_alf) begin
          pktout_en   = 1'b1;
          pktout_data = {8'b0, DST_MAC, SRC_MAC, ETH_TYPE, frame_seq, pkt_idx,
                         {HDR_PAD{1'b0}}};
          state_next  = S_AR;
        end
      end

      S_AR: begin
        // Address is built from registered state, so it holds until accepted.
        M_AXI_ARVALID = 1'b1;
        M_AXI_ARADDR  = base + {{(26 - BW){1'b0}}, burst_idx, 6'b0};
        M_AXI_ARLEN   = 8'd15;
        M_AXI_ARSIZE  = 3'b010;
        M_AXI_ARBURST = 2'b01;
        if (timeout)            state_next = S_DONE;
        else if (M_AXI_ARREADY) state_next = S_RD;
      end

      S_RD: begin
        M_AXI_RREADY = 1'b1;
        // The slave's RLAST ends the burst even when the beat count disagrees.
        if (timeout)                          state_next = S_DONE;
        else if (M_AXI_RVALID && M_AXI_RLAST) state_next = S_EMIT;
      end

      S_EMIT: begin
        if (!pktout_alf) begin
          pktout_en   = 1'b1;
          pktout_data = {8'b0, gather};
          if (pkt_end) begin
            pktout_md_en = 1'b1;
            pktout_md    = {pkt_bytes, frame_seq, pkt_idx, 208'b0};
          end
          if (last_burst)   state_next = S_DONE;
          else if (pkt_end) state_next = S_HDR;
          else              state_next = S_AR;
        end
      end

      S_DONE: begin
        frame_read_done_valid = 1'b1;
        frame_read_done       = ~err;
        if (frame_read_done_ready) state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= S_IDLE;
      base      <= '0;
      burst_idx <= '0;
      seg_cnt   <= '0;
      pkt_idx   <= '0;
      frame_seq <= '0;
      err       <= 1'b0;
      beat      <= '0;
    end else begin
      state <= state_next;

      case (state)
        S_IDLE: begin
          if (frame_read_start_valid) begin
            base      <= odd_even_flag ? BASE_ADDR1 : BASE_ADDR0;
            burst_idx <= '0;
            seg_cnt   <= '0;
            pkt_idx   <= '0;
            err       <= 1'b0;
            beat      <= '0;
          end
        end

        S_RD: begin
          if (r_hs) begin
            beat <= M_AXI_RLAST ? 4'd0 : beat + 4'd1;
            if (M_AXI_RRESP != 2'b00)             err <= 1'b1;
            if (M_AXI_RLAST != (beat == 4'd15))   err <= 1'b1;
          end
        end

        S_EMIT: begin
          if (!pktout_alf) begin
            burst_idx <= burst_idx + 1'b1;
            if (pkt_end) begin
              seg_cnt <= '0;
              pkt_idx <= pkt_idx + 16'd1;
            end else begin
              seg_cnt <= seg_cnt + 1'b1;
            end
          end
        end

        S_DONE: begin
          if (frame_read_done_ready) frame_seq <= frame_seq + 16'd1;
        end

        default: ;
      endcase

      if (timeout) err <= 1'b1;
    end
  end

  // NOTE: the gather buffer is pure datapath and is deliberately not reset;
  // it is only presented on the output after a full burst has overwritten it.
  always_ff @(posedge clk) begin
    if (r_hs) gather[32*beat +: 32] <= M_AXI_RDATA;
  end

endmodule
